memory_stage_unit: RTL and testbench

MEMORY_STAGE_UNIT -- requirements
Module: memory_stage_unit

---
 rtl/memory_stage_unit.sv | 132 +++++++++++++
 tb/tb_memory_stage_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_unit.sv
// MEM pipeline stage: issues one data-memory access per load/store, holds the
// pipeline until mem_ack (or timeout), and registers the MEM/WB fields.
module memory_stage_unit #(
  parameter int TIMEOUT = 15,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WB,
  input  logic              MEM_Read,
  input  logic              MEM_Write,
  input  logic              CALL,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] Reg2,
  input  logic [4:0]        R_dest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_stall,
  output logic              WB_out,
  output logic [4:0]        R_dest_out,
  output logic [DATA_W-1:0] WB_data,
  output logic              mem_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [4:0] TO_LIM = 5'(TIMEOUT);

  state_t            state, state_nxt;
  logic [3:0]        cnt_p0;
  logic [4:0]        cnt_inc;
  logic              access, conflict, done, timeout;
  logic [DATA_W-1:0] addr_p0, wdata_p0;
  logic              we_p0, wb_p0;
  logic [4:0]        rdest_p0;

  assign access   = MEM_Read ^ MEM_Write;
  assign conflict = MEM_Read & MEM_Write;
  assign cnt_inc  = {1'b0, cnt_p0} + 5'd1;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_stall = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = access;
        if (access) state_nxt = BUSY;
      end
      BUSY: begin
        mem_req   = 1'b1;
        mem_we    = we_p0;
        mem_addr  = addr_p0;
        mem_wdata = wdata_p0;
        mem_stall = !mem_ack;
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_inc == TO_LIM) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // p0: access latches captured from EX/MEM; MEM/WB outputs follow
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0     <= '0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      we_p0      <= 1'b0;
      wb_p0      <= 1'b0;
      rdest_p0   <= '0;
      WB_out     <= 1'b0;
      R_dest_out <= '0;
      WB_data    <= '0;
      mem_err    <= 1'b0;
    end else begin
      mem_err <= ((state == IDLE) && conflict) || timeout;
      if (state == IDLE) begin
        if (access) begin
          addr_p0    <= ALU_result;
          wdata_p0   <= Reg2;
          we_p0      <= MEM_Write;
          wb_p0      <= WB;
          rdest_p0   <= R_dest;
          cnt_p0     <= '0;
          WB_out     <= 1'b0;
          R_dest_out <= '0;
          WB_data    <= '0;
        end else if (conflict) begin
          WB_out     <= 1'b0;
          R_dest_out <= '0;
          WB_data    <= '0;
        end else begin
          WB_out     <= WB;
          R_dest_out <= R_dest;
          WB_data    <= CALL ? npc : ALU_result;
        end
      end else if (done) begin
        WB_out     <= wb_p0;
        R_dest_out <= rdest_p0;
        WB_data    <= we_p0 ? addr_p0 : mem_rdata;
      end else begin
        // Stalled or timed out: bubble into MEM/WB
        cnt_p0     <= cnt_inc[3:0];
        WB_out     <= 1'b0;
        R_dest_out <= '0;
        WB_data    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage_unit.sv
// Bench for memory_stage_unit: directed scenarios then random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_memory_stage_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB, MEM_Read, MEM_Write, CALL;
  logic [31:0] npc, ALU_result, Reg2, mem_rdata;
  logic [4:0]  R_dest;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_stall, WB_out, mem_err;
  logic [31:0] mem_addr, mem_wdata, WB_data;
  logic [4:0]  R_dest_out;

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding transaction plus the MEM/WB register view
  bit          pend;
  int          waited;
  bit          t_store, t_wb;
  logic [31:0] t_addr, t_wdata;
  logic [4:0]  t_rd;
  bit          x_wb, x_err;
  logic [4:0]  x_rd;
  logic [31:0] x_data;

  memory_stage_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .WB(WB), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
    .CALL(CALL), .npc(npc), .ALU_result(ALU_result), .Reg2(Reg2), .R_dest(R_dest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .WB_out(WB_out), .R_dest_out(R_dest_out), .WB_data(WB_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend = 0; waited = 0; t_store = 0; t_wb = 0; t_addr = '0; t_wdata = '0; t_rd = '0;
    x_wb = 0; x_rd = '0; x_data = '0; x_err = 0;
  endtask

  task automatic set_idle();
    reset = 0; WB = 0; MEM_Read = 0; MEM_Write = 0; CALL = 0;
    npc = '0; ALU_result = '0; Reg2 = '0; R_dest = '0; mem_rdata = '0; mem_ack = 0;
  endtask

  // Inputs are already applied; compare everything, advance the model one edge.
  task automatic tick();
    bit want_access, bubble;
    #1;
    want_access = (MEM_Read != MEM_Write);
    check("mem_req", {31'd0, mem_req}, {31'd0, pend});
    check("mem_we", {31'd0, mem_we}, {31'd0, pend && t_store});
    check("mem_addr", mem_addr, pend ? t_addr : 32'd0);
    check("mem_wdata", mem_wdata, pend ? t_wdata : 32'd0);
    check("mem_stall", {31'd0, mem_stall}, {31'd0, pend ? !mem_ack : want_access});
    check("WB_out", {31'd0, WB_out}, {31'd0, x_wb});
    check("R_dest_out", {27'd0, R_dest_out}, {27'd0, x_rd});
    check("WB_data", WB_data, x_data);
    check("mem_err", {31'd0, mem_err}, {31'd0, x_err});

    bubble = 1;
    x_err  = 0;
    if (reset) begin
      model_clear();
      bubble = 0;
    end else if (pend) begin
      if (mem_ack) begin
        pend = 0; bubble = 0;
        x_wb = t_wb; x_rd = t_rd; x_data = t_store ? t_addr : mem_rdata;
      end else begin
        waited++;
        if (waited >= TIMEOUT) begin
          pend = 0; x_err = 1;
        end
      end
    end else if (MEM_Read && MEM_Write) begin
      x_err = 1;
    end else if (want_access) begin
      pend = 1; waited = 0; t_store = MEM_Write; t_wb = WB;
      t_addr = ALU_result; t_wdata = Reg2; t_rd = R_dest;
    end else begin
      bubble = 0;
      x_wb = WB; x_rd = R_dest; x_data = CALL ? npc : ALU_result;
    end
    if (bubble) begin
      x_wb = 0; x_rd = '0; x_data = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    tick();

    // ALU pass-through
    set_idle(); WB = 1; R_dest = 5'd5; ALU_result = 32'h1234;
    tick();
    check("alu_wb_data", WB_data, 32'h1234);
    check("alu_rdest", {27'd0, R_dest_out}, 32'd5);

    // Load acked on the third BUSY cycle; EX/MEM inputs wiggle meanwhile
    set_idle(); WB = 1; MEM_Read = 1; ALU_result = 32'h100; R_dest = 5'd7;
    tick();
    set_idle(); MEM_Write = 1; ALU_result = 32'h999; R_dest = 5'd3;
    tick();
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("load_data", WB_data, 32'hDEADBEEF);
    check("load_rdest", {27'd0, R_dest_out}, 32'd7);

    // Store with immediate ack, WB=0
    set_idle(); MEM_Write = 1; ALU_result = 32'h200; Reg2 = 32'hCAFE;
    tick();
    set_idle(); mem_ack = 1;
    tick();
    check("store_wb", {31'd0, WB_out}, 32'd0);

    // CALL pass-through
    set_idle(); CALL = 1; WB = 1; npc = 32'h40; R_dest = 5'd31; ALU_result = 32'h77;
    tick();
    check("call_data", WB_data, 32'h40);
    check("call_rdest", {27'd0, R_dest_out}, 32'd31);

    // Read and write together
    set_idle(); MEM_Read = 1; MEM_Write = 1; WB = 1;
    tick();
    check("conflict_err", {31'd0, mem_err}, 32'd1);

    // Never-acked load times out
    set_idle(); WB = 1; MEM_Read = 1; ALU_result = 32'h300; R_dest = 5'd9;
    tick();
    set_idle();
    repeat (TIMEOUT) tick();
    check("timeout_err", {31'd0, mem_err}, 32'd1);
    check("timeout_wb", {31'd0, WB_out}, 32'd0);
    tick();

    // Reset mid-access with a simultaneous ack
    set_idle(); WB = 1; MEM_Read = 1; ALU_result = 32'h400; R_dest = 5'd4;
    tick();
    set_idle();
    tick();
    reset = 1; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    tick();
    set_idle();
    #1;
    check("rst_busy_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy_wb", {31'd0, WB_out}, 32'd0);
    check("rst_busy_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      WB         = 1'($urandom);
      MEM_Read   = ($urandom_range(0, 9) < 3);
      MEM_Write  = ($urandom_range(0, 9) < 3);
      CALL       = ($urandom_range(0, 9) < 2);
      npc        = $urandom;
      ALU_result = $urandom;
      Reg2       = $urandom;
      R_dest     = 5'($urandom);
      mem_rdata  = $urandom;
      mem_ack    = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
